// File: rtl/decoder_pkg.sv
// Shared types and the select-decode function for the decoder pipeline.
package decoder_pkg;

    // Decode modes; MODE_RSVD decodes as one-hot but flags an error.
    typedef enum logic [1:0] {
        ONEHOT    = 2'd0,
        THERMO    = 2'd1,
        ONEHOT_N  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // Widest vector the decode function can produce; callers keep the low WIDTH bits.
    localparam int unsigned MAX_W = 64;

    // Returns {err, vec}. Bits of vec at or above 'width' are meaningless.
    function automatic logic [MAX_W:0] decode(input int unsigned sel,
                                              input logic        en,
                                              input mode_e       mode,
                                              input int unsigned width);
        logic [MAX_W-1:0] oh;
        logic [MAX_W-1:0] th;
        logic [MAX_W-1:0] vec;
        logic             err;
        logic             in_range;
        oh       = '0;
        th       = '0;
        in_range = (sel < width);
        for (int unsigned i = 0; i < MAX_W; i++) begin
            oh[i] = (sel == i);
            th[i] = (i <= sel);
        end
        // A reserved mode is always flagged; an out-of-range index only matters when enabled.
        err = (mode == MODE_RSVD) || (en && !in_range);
        if (!en || !in_range) begin
            vec = (mode == ONEHOT_N) ? '1 : '0;
        end else begin
            case (mode)
                THERMO:   vec = th;
                ONEHOT_N: vec = ~oh;
                default:  vec = oh;
            endcase
        end
        return {err, vec};
    endfunction

endpackage

// File: rtl/decoder_if.sv
// Command-in / vector-out handshake bundle for decoder_pipe.
interface decoder_if #(
    parameter int SIZE  = 3,
    parameter int WIDTH = 1 << SIZE
);
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  in_sel;
    logic             in_en;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_vec;
    logic             out_err;

    // Command source / result consumer side.
    modport master (
        output in_valid, in_sel, in_en, in_mode, out_ready,
        input  in_ready, out_valid, out_vec, out_err
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_sel, in_en, in_mode, out_ready,
        output in_ready, out_valid, out_vec, out_err
    );
endinterface

// File: rtl/decoder_skid.sv
// Two-entry valid/ready buffer: a main output register plus one skid entry.
// in_ready comes straight from a flop, so it never sees out_ready combinationally.
module decoder_skid #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);
    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] main_data_q,  main_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q,  skid_data_d;
    logic          accept;
    logic          drain;

    assign accept      = in_valid_i && !skid_valid_q;
    assign drain       = main_valid_q && out_ready_i;
    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

    // Next-state: refill main from skid first (FIFO order), else from the input; overflow into skid.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_data_d = in_data_i;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    // State registers; reset empties both entries and clears the visible payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
endmodule

// File: rtl/decoder_pipe.sv
// Registered, flow-controlled select decoder: combinational decode feeding a 2-entry skid buffer.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int SIZE  = 3,
    parameter int WIDTH = 1 << SIZE
) (
    input  logic      clk,
    input  logic      rst_n,
    decoder_if.slave  bus
);
    logic [MAX_W:0]   dec_full;
    logic [WIDTH:0]   payload_in;
    logic [WIDTH:0]   payload_out;

    // Full-width index compare; sel is zero-extended, never truncated.
    assign dec_full   = decode(32'(bus.in_sel), bus.in_en, mode_e'(bus.in_mode), WIDTH);
    assign payload_in = {dec_full[MAX_W], dec_full[WIDTH-1:0]};

    // Decode bits above WIDTH are don't-care by construction.
    generate
        if (WIDTH < MAX_W) begin : g_spare
            logic unused_dec_bits;
            assign unused_dec_bits = ^dec_full[MAX_W-1:WIDTH];
        end
    endgenerate

    decoder_skid #(.DW(WIDTH + 1)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   (payload_in),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (payload_out)
    );

    assign bus.out_err = payload_out[WIDTH];
    assign bus.out_vec = payload_out[WIDTH-1:0];
endmodule
